rx_descr_s2p: RTL and testbench
===============================

# rx_descr_s2p

Receive STM-1 descrambler and serial-to-parallel converter, placed directly downstream of the receive frame aligner in `rx_stm_s2p`. It consumes the aligned serial stream and the scrambler-enable strobe (`sce`) produced by the aligner. It applies the frame-synchronous 1+x^6+x^7 descrambler to every bit outside the first 9 SOH bytes. It delivers MSB-first bytes with row/column position and a frame-start marker to the overhead and pointer stages.

## Interface
- `MAXROW`, 9, rows per frame
- `MAXCOL`, 270, bytes per row (STM-1: 3 × 90)
- `UNSCR`, 72, bits per frame left unscrambled (row 0, bytes 0–8)
- `clk155`  in  1  155.52 MHz bit clock
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset); all state and outputs clear
- `sdi`  in  1  serial data from the aligner, MSB of each byte first
- `sce`  in  1  scrambler enable from the aligner; 0 = unscrambled window
- `dout`  out  8  descrambled byte, bit 7 = first received bit
- `dval`  out  1  one-cycle strobe, `dout`/`row`/`col`/`fs` valid
- `fs`  out  1  frame start, high with `dval` for row 0, col 0 (first A1)
- `row`  out  4  row of current byte, 0..MAXROW-1
- `col`  out  9  column of current byte, 0..MAXCOL-1
- `aligned`  out  1  byte/frame alignment established
- `realign`  out  1  one-cycle pulse when an established alignment is moved

## Operation
- **Frame-start detection:** `sce_q` is `sce` delayed by one cycle (reset value 1). A cycle with `sce_q`=1 and `sce`=0 is a start event. In that cycle `sdi` is the MSB of the first A1 byte.
- **Start event handling:**
  - Bit counter is forced so that this bit is bit 7 of byte (row 0, col 0).
  - Any partial byte is discarded.
  - `aligned` is set.
- **`realign` pulse:** if `aligned` was already 1 and the internal position was not (row 0, col 0, bit 7), `realign` pulses.
- **Descrambler:** 7-bit LFSR `s`.
  - While `sce`=0: `s` is held at 7'h7F, and `sdi` passes unchanged.
  - While `sce`=1: descrambled bit = `sdi ^ s[6]`, then `s <= {s[5:0], s[6]^s[5]}`.
  - The first scrambled bit therefore sees sequence bits 1111111 0000001…
- **Counters:**
  - Bit counter runs 7→0.
  - `col` wraps MAXCOL-1→0 and increments `row`.
  - `row` wraps MAXROW-1→0.
  - Counters free-run after alignment, with no need for further start events.
- **Before first alignment:** `dval`, `fs`, `realign` stay 0. The LFSR still follows `sce`.
- **Simultaneous events:** a start event exactly at the expected frame start gives the same result as a natural wrap, with no `realign` pulse. A start event while `sce` is already 0 cannot occur, since edge detection requires `sce_q`=1.

## Timing
- Reset values: `dout`=0, `dval`=0, `fs`=0, `row`=0, `col`=0, `aligned`=0, `realign`=0. Internally, LFSR = 7'h7F and `sce_q`=1.
- **Output latency:** `dout` and `dval` are registered. They appear in the cycle after the LSB (bit 0) of a byte is sampled.
- `dval` is high exactly 1 cycle in 8 once aligned. `row`, `col` and `fs` are aligned with it and hold until the next `dval`.
- `realign` is high in the cycle after the start event.
- `aligned` rises in the cycle after the first start event.
- Reset asserted mid-byte or mid-frame clears everything immediately. After release, the block waits for a new start event.

## Configuration
- **`RX_S2P_FLYWHEEL_EN` defined:**
  - Once `aligned`=1, start events at any position other than the expected (row 0, col 0, bit 7) are ignored for both alignment and LFSR reload.
  - The unscrambled window is generated from the internal counters: bits 0..UNSCR-1 of the frame, with the LFSR held at 7'h7F.
  - If 3 consecutive expected frame starts pass with no coincident start event, `aligned` clears. The next start event then realigns and pulses `realign`.
- **`RX_S2P_FLYWHEEL_EN` undefined:**
  - Every start event realigns.
  - The LFSR follows `sce` only.

## Test plan
- **Frame start:** reset, then send `sce` 1→0 with `sdi`=F6 F6 F6 28 28 28 over the first 6 bytes. Required: first `dval` with `fs`=1, `row`=0, `col`=0, `dout`=F6; sixth byte `dout`=28, `col`=5.
- **Descrambler sequence:** after the 72-bit window, `sce`=1 with `sdi` all zero. Required: bytes at col 9..16 = FE 04 18 51 E4 59 D4 FA.
- **Steady state:** send two full frames (19440 bits each) with start events every frame. Required: `col` wraps 269→0, `row` wraps 8→0, `fs` once per frame, `realign` never pulses.
- **Moved start:** inject a start event 3 bits late in frame 2. Without the macro: `realign`=1 for one cycle, and the next `dval` follows 8 cycles after the new MSB. With `RX_S2P_FLYWHEEL_EN`: event ignored, no `realign`.
- **Reset mid-frame:** assert `rst`=0 mid-frame. Required: all outputs 0 immediately; after release, `dval` stays 0 until the next start event.
- **Flywheel loss:** with `RX_S2P_FLYWHEEL_EN`, hold `sce`=1 for 3 frames. Required: `aligned` falls after the third missed frame start, and a later start event sets `aligned` with `realign`=1.

Source files
------------

// File: rtl/rx_descr_s2p.sv
// STM-1 receive descrambler (1+x^6+x^7) and serial-to-parallel converter with row/column tracking.
// Optional RX_S2P_FLYWHEEL_EN: counter-driven unscrambled window, off-position starts ignored, loss after 3 missed frames.
module rx_descr_s2p #(
  parameter int MAXROW = 9,
  parameter int MAXCOL = 270,
  parameter int UNSCR  = 72
) (
  input  logic       clk155,
  input  logic       rst,
  input  logic       sdi,
  input  logic       sce,
  output logic [7:0] dout,
  output logic       dval,
  output logic       fs,
  output logic [3:0] row,
  output logic [8:0] col,
  output logic       aligned,
  output logic       realign
);

  logic       sce_q;
  logic [6:0] lfsr;
  logic [6:0] lfsr_nxt;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] pos_row;
  logic [8:0] pos_col;

  logic       start_ev;
  logic       at_exp;
  logic       start_acc;
  logic       unscr;
  logic       dbit;
  logic [2:0] eff_bit;
  logic [2:0] bit_nxt;
  logic [3:0] eff_row;
  logic [3:0] row_nxt;
  logic [8:0] eff_col;
  logic [8:0] col_nxt;

  if (UNSCR > MAXCOL * 8 || MAXROW > 16 || MAXCOL > 512) begin : g_bad_cfg
    $error("rx_descr_s2p: frame geometry does not fit the position counters");
  end

  // The falling edge of the aligner's scrambler enable marks the MSB of the first A1.
  assign start_ev = sce_q & ~sce;
  assign at_exp   = (bit_cnt == 3'd7) && (pos_row == '0) && (pos_col == '0);

`ifdef RX_S2P_FLYWHEEL_EN
  logic [1:0]  miss_cnt;
  logic        lost;
  logic [11:0] frame_bit;

  assign frame_bit = {eff_col, 3'b000} + {9'd0, ~eff_bit};
  assign start_acc = start_ev & (~aligned | at_exp);
  assign unscr     = aligned ? ((eff_row == '0) && (frame_bit < 12'(UNSCR))) : ~sce;
`else
  assign start_acc = start_ev;
  assign unscr     = ~sce;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    eff_bit = bit_cnt;
    eff_row = pos_row;
    eff_col = pos_col;
    if (start_acc) begin
      eff_bit = 3'd7;
      eff_row = '0;
      eff_col = '0;
    end
    bit_nxt = eff_bit - 3'd1;
    row_nxt = eff_row;
    col_nxt = eff_col;
    if (eff_bit == 3'd0) begin
      if (eff_col == 9'(MAXCOL - 1)) begin
        col_nxt = '0;
        row_nxt = (eff_row == 4'(MAXROW - 1)) ? '0 : eff_row + 4'd1;
      end else begin
        col_nxt = eff_col + 9'd1;
      end
    end
  end

  always_comb begin
    dbit     = sdi;
    lfsr_nxt = 7'h7F;
    if (!unscr) begin
      dbit     = sdi ^ lfsr[6];
      lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk155 or negedge rst) begin
    if (!rst) begin
      sce_q   <= 1'b1;
      lfsr    <= 7'h7F;
      shreg   <= '0;
      bit_cnt <= 3'd7;
      pos_row <= '0;
      pos_col <= '0;
      dout    <= '0;
      dval    <= 1'b0;
      fs      <= 1'b0;
      row     <= '0;
      col     <= '0;
    end else begin
      sce_q   <= sce;
      lfsr    <= lfsr_nxt;
      shreg   <= {shreg[5:0], dbit};
      bit_cnt <= bit_nxt;
      pos_row <= row_nxt;
      pos_col <= col_nxt;
      if (aligned && eff_bit == 3'd0) begin
        dval <= 1'b1;
        dout <= {shreg, dbit};
        row  <= eff_row;
        col  <= eff_col;
        fs   <= (eff_row == '0) && (eff_col == '0);
      end else begin
        dval <= 1'b0;
      end
    end
  end

`ifdef RX_S2P_FLYWHEEL_EN
  // Alignment is lost only after three consecutive expected frame starts pass without a start event.
  always_ff @(posedge clk155 or negedge rst) begin
    if (!rst) begin
      aligned  <= 1'b0;
      realign  <= 1'b0;
      miss_cnt <= '0;
      lost     <= 1'b0;
    end else begin
      realign <= start_acc & lost;
      if (start_acc) begin
        aligned  <= 1'b1;
        miss_cnt <= '0;
        lost     <= 1'b0;
      end else if (aligned && at_exp) begin
        if (miss_cnt == 2'd2) begin
          aligned  <= 1'b0;
          miss_cnt <= '0;
          lost     <= 1'b1;
        end else begin
          miss_cnt <= miss_cnt + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk155 or negedge rst) begin
    if (!rst) begin
      aligned <= 1'b0;
      realign <= 1'b0;
    end else begin
      realign <= start_acc & aligned & ~at_exp;
      aligned <= aligned | start_acc;
    end
  end
`endif

endmodule

// File: tb/tb_rx_descr_s2p.sv
// Directed bench for rx_descr_s2p: frame start, descrambler bytes, wraps, moved start, reset, flywheel loss.
module tb_rx_descr_s2p;

  localparam int MAXROW      = 9;
  localparam int MAXCOL      = 270;
  localparam int UNSCR       = 72;
  localparam int FRAME_BYTES = MAXROW * MAXCOL;
  localparam int FBITS       = FRAME_BYTES * 8;
  localparam int NVEC        = 14;

  logic       clk155 = 1'b0;
  logic       rst    = 1'b1;
  logic       sdi    = 1'b0;
  logic       sce    = 1'b1;
  logic [7:0] dout;
  logic       dval;
  logic       fs;
  logic [3:0] row;
  logic [8:0] col;
  logic       aligned;
  logic       realign;

  rx_descr_s2p dut (
    .clk155 (clk155),
    .rst    (rst),
    .sdi    (sdi),
    .sce    (sce),
    .dout   (dout),
    .dval   (dval),
    .fs     (fs),
    .row    (row),
    .col    (col),
    .aligned(aligned),
    .realign(realign)
  );

  always #3 clk155 = ~clk155;

  typedef struct {
    int         col;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_fs;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic [3:0] row;
    logic [8:0] col;
    logic       fs;
    int         cyc;
  } cap_t;

  vec_t vecs[NVEC];
  cap_t caps[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   realign_cnt = 0;
  int   last_realign_cyc = -1;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  logic prev_aligned = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int c, input logic [7:0] din, input logic [7:0] ed,
                         input logic efs);
    vecs[i].col      = c;
    vecs[i].din      = din;
    vecs[i].exp_dout = ed;
    vecs[i].exp_fs   = efs;
  endtask

  function automatic logic [7:0] frame_byte(input int idx);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NVEC; i++)
      if (vecs[i].col == idx) v = vecs[i].din;
    return v;
  endfunction

  // One bit per clock; registered outputs are observed 1 time unit after the edge.
  task automatic tick(input logic b, input logic s);
    sdi = b;
    sce = s;
    @(posedge clk155);
    #1;
    cyc++;
    if (dval) caps.push_back('{dout, row, col, fs, cyc});
    if (realign) begin
      realign_cnt++;
      last_realign_cyc = cyc;
    end
    if (aligned && !prev_aligned) rise_cyc = cyc;
    if (!aligned && prev_aligned) fall_cyc = cyc;
    prev_aligned = aligned;
  endtask

  task automatic send_frame(input int late, input bit with_start, input int nbits);
    logic [7:0] v;
    logic       s;
    for (int i = 0; i < nbits; i++) begin
      v = frame_byte(i / 8);
      s = !(with_start && i >= late && i < late + UNSCR);
      tick(v[7 - (i % 8)], s);
    end
  endtask

  function automatic int first_after(input int c);
    for (int i = 0; i < caps.size(); i++)
      if (caps[i].cyc > c) return i;
    return -1;
  endfunction

  task automatic check_resume(input string name, input int c, input int exp_cyc);
    int         k;
    int         got_cyc;
    logic       got_fs;
    logic [3:0] got_row;
    logic [8:0] got_col;
    k       = first_after(c);
    got_cyc = -1;
    got_fs  = 1'b0;
    got_row = '1;
    got_col = '1;
    if (k >= 0) begin
      got_cyc = caps[k].cyc;
      got_fs  = caps[k].fs;
      got_row = caps[k].row;
      got_col = caps[k].col;
    end
    check({name, " dval cycle"}, got_cyc, exp_cyc);
    check({name, " fs"}, got_fs, 1);
    check({name, " row"}, got_row, 0);
    check({name, " col"}, got_col, 0);
  endtask

  task automatic check_cap(input string name, input int k, input int erow, input int ecol,
                           input logic efs);
    if (k < caps.size()) begin
      check({name, " row"}, caps[k].row, erow);
      check({name, " col"}, caps[k].col, ecol);
      check({name, " fs"}, caps[k].fs, efs);
    end else begin
      check({name, " present"}, caps.size(), k + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dout"}, dout, 0);
    check({tag, " dval"}, dval, 0);
    check({tag, " fs"}, fs, 0);
    check({tag, " row"}, row, 0);
    check({tag, " col"}, col, 0);
    check({tag, " aligned"}, aligned, 0);
    check({tag, " realign"}, realign, 0);
  endtask

  initial begin
    int f1, f2, f3, c3, s0, k, errs, fs_n, n0, rc0, exp_row, exp_col;

    set_vec(0, 0, 8'hF6, 8'hF6, 1'b1);
    set_vec(1, 1, 8'hF6, 8'hF6, 1'b0);
    set_vec(2, 2, 8'hF6, 8'hF6, 1'b0);
    set_vec(3, 3, 8'h28, 8'h28, 1'b0);
    set_vec(4, 4, 8'h28, 8'h28, 1'b0);
    set_vec(5, 5, 8'h28, 8'h28, 1'b0);
    set_vec(6, 9, 8'h00, 8'hFE, 1'b0);
    set_vec(7, 10, 8'h00, 8'h04, 1'b0);
    set_vec(8, 11, 8'h00, 8'h18, 1'b0);
    set_vec(9, 12, 8'h00, 8'h51, 1'b0);
    set_vec(10, 13, 8'h00, 8'hE4, 1'b0);
    set_vec(11, 14, 8'h00, 8'h59, 1'b0);
    set_vec(12, 15, 8'h00, 8'hD4, 1'b0);
    set_vec(13, 16, 8'h00, 8'hFA, 1'b0);

    #1 rst = 1'b0;
    repeat (3) @(posedge clk155);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    repeat (16) tick(1'($urandom_range(0, 1)), 1'b1);
    check("no dval before alignment", caps.size(), 0);
    check("aligned before start", aligned, 0);

    f1 = cyc + 1;
    send_frame(0, 1'b1, FBITS);
    f2 = cyc + 1;
    send_frame(0, 1'b1, FBITS);
    check("aligned rise cycle", rise_cyc, f1);
    check("first dval cycle", (caps.size() > 0) ? caps[0].cyc : -1, f1 + 7);
    check("byte count two frames", caps.size(), 2 * FRAME_BYTES);
    check("no realign steady", realign_cnt, 0);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NVEC; i++) begin
        k = f * FRAME_BYTES + vecs[i].col;
        if (k < caps.size()) begin
          check($sformatf("frame%0d col%0d dout", f + 1, vecs[i].col), caps[k].dout, vecs[i].exp_dout);
          check($sformatf("frame%0d col%0d pos", f + 1, vecs[i].col), {caps[k].row, caps[k].col},
                {4'd0, 9'(vecs[i].col)});
          check($sformatf("frame%0d col%0d fs", f + 1, vecs[i].col), caps[k].fs, vecs[i].exp_fs);
        end else begin
          check($sformatf("frame%0d col%0d present", f + 1, vecs[i].col), caps.size(), k + 1);
        end
      end
    end

    errs = 0;
    fs_n = 0;
    for (int i = 0; i < 2 * FRAME_BYTES && i < caps.size(); i++) begin
      exp_col = i % MAXCOL;
      exp_row = (i / MAXCOL) % MAXROW;
      if (caps[i].col !== 9'(exp_col) || caps[i].row !== 4'(exp_row)) errs++;
      if (caps[i].fs !== ((exp_row == 0) && (exp_col == 0))) errs++;
      if (caps[i].fs) fs_n++;
      if (i > 0 && caps[i].cyc - caps[i - 1].cyc != 8) errs++;
    end
    check("steady position/fs/spacing errors", errs, 0);
    check("fs count two frames", fs_n, 2);
    check_cap("col wrap 269", MAXCOL - 1, 0, MAXCOL - 1, 1'b0);
    check_cap("col wrap 0", MAXCOL, 1, 0, 1'b0);
    check_cap("row wrap last", FRAME_BYTES - 1, MAXROW - 1, MAXCOL - 1, 1'b0);
    check_cap("row wrap first", FRAME_BYTES, 0, 0, 1'b1);
    check("frame2 start dval cycle", (caps.size() > FRAME_BYTES) ? caps[FRAME_BYTES].cyc : -1, f2 + 7);

    f3 = cyc + 1;
    c3 = f3 + 3;
`ifdef RX_S2P_FLYWHEEL_EN
    send_frame(3, 1'b1, FBITS);
    check("moved start ignored realign", realign_cnt, 0);
    check_resume("moved start ignored", c3, f3 + 7);
    check("aligned after one miss", aligned, 1);
    send_frame(0, 1'b0, FBITS);
    check("aligned after two misses", aligned, 1);
    s0 = cyc + 1;
    send_frame(0, 1'b0, 100);
    check("aligned fall cycle", fall_cyc, s0);
    check("aligned low after loss", aligned, 0);
    s0 = cyc + 1;
    send_frame(0, 1'b1, UNSCR + 24);
    check("relock aligned", aligned, 1);
    check("relock realign count", realign_cnt, 1);
    check("relock realign cycle", last_realign_cyc, s0);
    check_resume("relock", s0, s0 + 7);
    send_frame(0, 1'b0, 203);
`else
    send_frame(3, 1'b1, 300);
    check("moved start realign count", realign_cnt, 1);
    check("moved start realign cycle", last_realign_cyc, c3);
    check_resume("moved start", c3, c3 + 7);
`endif

    rst = 1'b0;
    #1;
    check_reset_outputs("mid-frame reset");
    repeat (2) @(posedge clk155);
    #1;
    rst = 1'b1;
    n0  = caps.size();
    rc0 = realign_cnt;
    repeat (40) tick(1'($urandom_range(0, 1)), 1'b1);
    check("no dval after reset release", caps.size(), n0);
    check("aligned low after reset release", aligned, 0);
    s0 = cyc + 1;
    send_frame(0, 1'b1, UNSCR + 16);
    check("post-reset aligned rise", rise_cyc, s0);
    check("post-reset no realign", realign_cnt, rc0);
    check_resume("post-reset start", s0, s0 + 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
